// File: rtl/clock_setup_ctrl.sv
// Front-panel setup controller: maps debounced buttons to run/setup mode,
// active-low field selects, and single-cycle adjust ticks with auto-repeat.
module clock_setup_ctrl #(
    parameter int unsigned HOLD_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned TIMEOUT       = 500_000_000,
    parameter int unsigned BLINK_HALF    = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_up,
    input  logic btn_down,
    output logic display,
    output logic setup_hour,
    output logic setup_minute,
    output logic setup_second,
    output logic inc_dec,
    output logic tick,
    output logic blink
);

    localparam int unsigned RPT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW = $clog2(RPT_MAX) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned BW = $clog2(BLINK_HALF) + 1;

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    state_t        state, next_state;
    logic          mode_q, up_q, down_q;
    logic          armed, arm_up, repeating;
    logic [RW-1:0] rpt_cnt, rpt_limit;
    logic [TW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    logic mode_edge, up_edge, down_edge, both, in_set, idle, timeout_hit;
    logic state_change, edge_tick, hold_ok, rpt_fire, do_tick;

    always_comb begin
        mode_edge   = btn_mode & ~mode_q;
        up_edge     = btn_up & ~up_q;
        down_edge   = btn_down & ~down_q;
        both        = btn_up & btn_down;
        in_set      = (state != RUN);
        idle        = in_set & ~btn_mode & ~btn_up & ~btn_down;
        timeout_hit = idle && (idle_cnt == TW'(TIMEOUT - 1));

        next_state = state;
        if (mode_edge) begin
            case (state)
                RUN:      next_state = SET_HOUR;
                SET_HOUR: next_state = SET_MIN;
                SET_MIN:  next_state = SET_SEC;
                default:  next_state = RUN;
            endcase
        end else if (timeout_hit) begin
            next_state = RUN;
        end
        state_change = (next_state != state);

        // A mode edge always wins; pressing both buttons suppresses and disarms repeat.
        edge_tick = in_set & ~mode_edge & ~both & (up_edge | down_edge);
        hold_ok   = in_set & armed & ~mode_edge & ~both & (arm_up ? btn_up : btn_down);
        rpt_limit = repeating ? RW'(REPEAT_PERIOD - 1) : RW'(HOLD_DELAY - 1);
        rpt_fire  = hold_ok && (rpt_cnt == rpt_limit);
        do_tick   = edge_tick | rpt_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            mode_q       <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            armed        <= 1'b0;
            arm_up       <= 1'b0;
            repeating    <= 1'b0;
            rpt_cnt      <= '0;
            idle_cnt     <= '0;
            blink_cnt    <= '0;
            display      <= 1'b0;
            setup_hour   <= 1'b1;
            setup_minute <= 1'b1;
            setup_second <= 1'b1;
            inc_dec      <= 1'b1;
            tick         <= 1'b0;
            blink        <= 1'b0;
        end else begin
            mode_q <= btn_mode;
            up_q   <= btn_up;
            down_q <= btn_down;
            state  <= next_state;

            display      <= (next_state != RUN);
            setup_hour   <= (next_state != SET_HOUR);
            setup_minute <= (next_state != SET_MIN);
            setup_second <= (next_state != SET_SEC);

            tick <= do_tick;
            if (do_tick)
                inc_dec <= edge_tick ? up_edge : arm_up;

            if (edge_tick) begin
                armed     <= 1'b1;
                arm_up    <= up_edge;
                repeating <= 1'b0;
                rpt_cnt   <= '0;
            end else if (rpt_fire) begin
                repeating <= 1'b1;
                rpt_cnt   <= '0;
            end else if (hold_ok) begin
                if (rpt_cnt != '1)
                    rpt_cnt <= rpt_cnt + 1'b1;
            end else begin
                armed     <= 1'b0;
                repeating <= 1'b0;
                rpt_cnt   <= '0;
            end

            if (state_change || !idle)
                idle_cnt <= '0;
            else if (idle_cnt != '1)
                idle_cnt <= idle_cnt + 1'b1;

            // Blink phase restarts high on entry to a field and after every tick.
            if (next_state == RUN) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (state_change || do_tick) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule
